// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling and a saturating
// count of injected load-use bubbles.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_alusrc,
  input  logic             id_branch,
  input  logic             id_is_c,
  input  logic [3:0]       id_aluop,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_alusrc,
  output logic             ex_branch,
  output logic             ex_is_c,
  output logic [3:0]       ex_aluop,
  output logic             lu_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic            branch;
    logic            is_c;
    logic [3:0]      aluop;
  } ex_t;

  ex_t             ex_d, ex_q, id_s;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic            rs1_hit, rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_q.rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_q.rd);
  assign lu_stall = !flush && !hold && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                    id_valid && (rs1_hit || rs2_hit);

  always_comb begin
    id_s.valid    = id_valid;
    id_s.pc       = id_pc;
    id_s.rs1_data = id_rs1_data;
    id_s.rs2_data = id_rs2_data;
    id_s.imm      = id_imm;
    id_s.rs1      = id_rs1;
    id_s.rs2      = id_rs2;
    id_s.rd       = id_rd;
    // Side-effecting controls only travel with a valid instruction
    id_s.regwrite = id_regwrite && id_valid;
    id_s.memread  = id_memread  && id_valid;
    id_s.memwrite = id_memwrite && id_valid;
    id_s.memtoreg = id_memtoreg && id_valid;
    id_s.branch   = id_branch   && id_valid;
    id_s.alusrc   = id_alusrc;
    id_s.is_c     = id_is_c;
    id_s.aluop    = id_aluop;
  end

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d          = id_s;
      ex_d.valid    = 1'b0;
      ex_d.regwrite = 1'b0;
      ex_d.memread  = 1'b0;
      ex_d.memwrite = 1'b0;
      ex_d.memtoreg = 1'b0;
      ex_d.branch   = 1'b0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (lu_stall) begin
      // Bubble: rd cleared so the forwarding unit can never match it
      ex_d          = id_s;
      ex_d.valid    = 1'b0;
      ex_d.regwrite = 1'b0;
      ex_d.memread  = 1'b0;
      ex_d.memwrite = 1'b0;
      ex_d.memtoreg = 1'b0;
      ex_d.branch   = 1'b0;
      ex_d.rd       = 5'd0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d = id_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_branch   = ex_q.branch;
  assign ex_is_c     = ex_q.is_c;
  assign ex_aluop    = ex_q.aluop;
  assign bubble_cnt  = cnt_q;

endmodule
